// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide execute unit. One radix-2 step per
//            cycle on a 2*XLEN accumulator (shift-add multiply, restoring
//            divide), sign fixup in FINISH, registered Result and Done pulse.
//            Optional macro MULDIV_FAST_MUL_EN: MUL* ops bypass the iteration
//            and use a single combinational 2*XLEN multiply in FINISH.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start,
    input  logic            Flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);
    localparam int                 c_cnt_w    = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(XLEN - 1);
    localparam logic [XLEN-1:0]    c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                state_q,    state_d;
    logic [c_cnt_w-1:0]    cnt_q,      cnt_d;
    logic [2:0]            op_q,       op_d;
    logic [XLEN-1:0]       opnd_q,     opnd_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]     acc_q,      acc_d;
    logic                  sign_res_q, sign_res_d; // negate product / quotient
    logic                  sign_rem_q, sign_rem_d; // remainder follows dividend
    logic                  special_q,  special_d;  // acc low half already holds the answer
    logic [XLEN-1:0]       result_q,   result_d;
    logic                  done_q,     done_d;

    // Operand decode: which sources are treated as two's complement
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
    assign w_b_signed = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    assign w_a_neg    = w_a_signed && SrcA[XLEN-1];
    assign w_b_neg    = w_b_signed && SrcB[XLEN-1];
    assign w_a_mag    = w_a_neg ? -SrcA : SrcA;
    assign w_b_mag    = w_b_neg ? -SrcB : SrcB;

    // Shift-add multiply step: conditionally add multiplicand to the high half, then shift right
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_step;
    assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign w_mul_step = {w_mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide step: shift left, subtract divisor from the partial remainder if it fits
    logic [2*XLEN:0]   w_div_shift;
    logic [XLEN:0]     w_div_top;
    logic [XLEN-1:0]   w_div_diff;
    logic [2*XLEN-1:0] w_div_step;
    assign w_div_shift = {acc_q, 1'b0};
    assign w_div_top   = w_div_shift[2*XLEN:XLEN];
    assign w_div_diff  = w_div_top[XLEN-1:0] - opnd_q;
    assign w_div_step  = (w_div_top >= {1'b0, opnd_q})
                       ? {w_div_diff, w_div_shift[XLEN-1:1], 1'b1}
                       : w_div_shift[2*XLEN-1:0];

    // Final sign fixup and result selection
    logic [2*XLEN-1:0] w_prod_mag, w_prod;
    logic [XLEN-1:0]   w_quot, w_rem, w_final;
`ifdef MULDIV_FAST_MUL_EN
    assign w_prod_mag = op_q[2] ? acc_q
                      : ({{XLEN{1'b0}}, opnd_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]});
`else
    assign w_prod_mag = acc_q;
`endif
    assign w_prod = sign_res_q ? -w_prod_mag : w_prod_mag;
    assign w_quot = sign_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign w_rem  = sign_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    // Pick the architectural result for the latched op
    always_comb begin
        w_final = w_prod[XLEN-1:0];
        if (special_q)             w_final = acc_q[XLEN-1:0];
        else if (op_q == 3'b000)   w_final = w_prod[XLEN-1:0];
        else if (!op_q[2])         w_final = w_prod[2*XLEN-1:XLEN];
        else if (!op_q[1])         w_final = w_quot;
        else                       w_final = w_rem;
    end

    // Next-state logic: launch, iterate, finish; Flush overrides everything
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        sign_res_d = sign_res_q;
        sign_rem_d = sign_rem_q;
        special_d  = special_q;
        result_d   = result_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done_q still high means Busy is high: the Done cycle never launches
                if (Start && !Flush && !done_q) begin
                    op_d       = funct3;
                    cnt_d      = c_cnt_init;
                    special_d  = 1'b0;
                    sign_res_d = w_a_neg ^ w_b_neg;
                    sign_rem_d = w_a_neg;
                    if (funct3[2]) begin
                        opnd_d = w_b_mag;
                        acc_d  = {{XLEN{1'b0}}, w_a_mag};
                        if (SrcB == '0) begin
                            special_d = 1'b1;
                            acc_d     = {{XLEN{1'b0}}, (funct3[1] ? SrcA : {XLEN{1'b1}})};
                            state_d   = S_FINISH;
                        end else if (!funct3[0] && SrcA == c_int_min && SrcB == {XLEN{1'b1}}) begin
                            special_d = 1'b1;
                            acc_d     = {{XLEN{1'b0}}, (funct3[1] ? {XLEN{1'b0}} : c_int_min)};
                            state_d   = S_FINISH;
                        end else begin
                            state_d   = S_CALC;
                        end
                    end else begin
                        opnd_d = w_a_mag;
                        acc_d  = {{XLEN{1'b0}}, w_b_mag};
`ifdef MULDIV_FAST_MUL_EN
                        state_d = S_FINISH;
`else
                        state_d = S_CALC;
`endif
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? w_div_step : w_mul_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FINISH;
            end
            S_FINISH: begin
                result_d = w_final;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (Flush) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            sign_res_q <= 1'b0;
            sign_rem_q <= 1'b0;
            special_q  <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            sign_res_q <= sign_res_d;
            sign_rem_q <= sign_rem_d;
            special_q  <= special_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    // Busy covers the whole op including the Done cycle, so a Start there is ignored
    assign Busy   = (state_q != S_IDLE) || done_q;
    assign Done   = done_q;
    assign Result = result_q;

endmodule
`default_nettype wire
